// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_stage
// Brief    : Issue/capture wrapper around a 1-cycle registered ALU. Credits cap
//            in-flight ops at DEPTH so results always fit in the result FIFO.
//            Optional macro ALU_ISSUE_STATS_EN adds the stall_cnt_o counter.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_stage #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_first_i,
  input  logic [WIDTH-1:0] in_second_i,
  input  logic [2:0]       in_opcode_i,
  output logic [WIDTH-1:0] alu_first_o,
  output logic [WIDTH-1:0] alu_second_o,
  output logic [2:0]       alu_opcode_o,
  input  logic [WIDTH-1:0] alu_result_i,
`ifdef ALU_ISSUE_STATS_EN
  output logic [15:0]      stall_cnt_o,
`endif
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_result_o,
  output logic [2:0]       out_opcode_o
);

  localparam int              c_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              c_CW    = c_AW + 1;
  localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);

  logic             w_accept;
  logic             w_pop;
  logic             w_push;
  logic [c_AW-1:0]  w_head;

  logic [WIDTH-1:0] r_alu_first;
  logic [WIDTH-1:0] r_alu_second;
  logic [2:0]       r_alu_opcode;
  logic             r_v1;
  logic             r_v2;
  logic [2:0]       r_tag2;
  logic [c_CW-1:0]  r_cnt;
  logic [c_CW-1:0]  r_wr_ptr;
  logic [c_CW-1:0]  r_rd_ptr;
  logic [WIDTH-1:0] r_mem_res [DEPTH];
  logic [2:0]       r_mem_op  [DEPTH];

  // in_ready_o depends on the credit counter only, never on same-cycle inputs.
  assign in_ready_o  = (r_cnt < c_DEPTH);
  assign w_accept    = in_valid_i && in_ready_o;
  assign out_valid_o = (r_wr_ptr != r_rd_ptr);
  assign w_pop       = out_valid_o && out_ready_i;
  assign w_push      = r_v2;
  assign w_head      = r_rd_ptr[c_AW-1:0];

  assign alu_first_o  = r_alu_first;
  assign alu_second_o = r_alu_second;
  assign alu_opcode_o = r_alu_opcode;

  // The operand opcode register doubles as the first stage of the tag pipeline.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_alu_first  <= '0;
      r_alu_second <= '0;
      r_alu_opcode <= '0;
      r_v1         <= 1'b0;
      r_v2         <= 1'b0;
      r_tag2       <= '0;
    end else begin
      if (w_accept) begin
        r_alu_first  <= in_first_i;
        r_alu_second <= in_second_i;
        r_alu_opcode <= in_opcode_i;
      end
      r_v1   <= w_accept;
      r_v2   <= r_v1;
      r_tag2 <= r_alu_opcode;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else begin
      case ({w_accept, w_pop})
        2'b10:   r_cnt <= r_cnt + c_CW'(1);
        2'b01:   r_cnt <= r_cnt - c_CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_CW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem_res[r_wr_ptr[c_AW-1:0]] <= alu_result_i;
      r_mem_op[r_wr_ptr[c_AW-1:0]]  <= r_tag2;
    end
  end

  // Storage is not reset, so the head is masked to zero while the FIFO is empty.
  assign out_result_o = out_valid_o ? r_mem_res[w_head] : '0;
  assign out_opcode_o = out_valid_o ? r_mem_op[w_head]  : '0;

`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stall_cnt <= '0;
    end else if (in_valid_i && !in_ready_o && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`endif

endmodule
`default_nettype wire
